// File: rtl/yuv2rgb_pkg.sv
// Shared types and constants for the YUV-to-RGB converter: FSM states and
// BT.601 coefficients (signed, 16 fractional bits) for limited and full range.
package yuv2rgb_pkg;

   typedef enum logic [2:0] {S_IDLE, S_Y, S_V, S_U, S_OUT} state_t;

   localparam int FRAC_BITS  = 16;
   localparam int ROUND_HALF = 32768;
   localparam int COEF_W     = 19;

   typedef struct packed {
      logic signed [COEF_W-1:0] ky;
      logic signed [COEF_W-1:0] krv;
      logic signed [COEF_W-1:0] kgv;
      logic signed [COEF_W-1:0] kgu;
      logic signed [COEF_W-1:0] kbu;
   } coef_t;

   localparam coef_t COEF_LIM = '{ky:  19'sd76284,  krv: 19'sd104595,
                                  kgv: 19'sd53281,  kgu: 19'sd25624,
                                  kbu: 19'sd132251};

   localparam coef_t COEF_FULL = '{ky:  19'sd65536, krv: 19'sd91881,
                                   kgv: 19'sd46802, kgu: 19'sd22554,
                                   kbu: 19'sd116130};

endpackage

// File: rtl/yuv2rgb_pipe_if.sv
// Pixel stream bundle: YUV input handshake and RGB output handshake.
// slave is the converter side, master is the source/sink side.
interface yuv2rgb_pipe_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] Y_in;
   logic [DATA_W-1:0] U_in;
   logic [DATA_W-1:0] V_in;
   logic              full_range;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] R_out;
   logic [DATA_W-1:0] G_out;
   logic [DATA_W-1:0] B_out;

   modport slave (
      input  in_valid, Y_in, U_in, V_in, full_range, out_ready,
      output in_ready, out_valid, R_out, G_out, B_out
   );

   modport master (
      output in_valid, Y_in, U_in, V_in, full_range, out_ready,
      input  in_ready, out_valid, R_out, G_out, B_out
   );
endinterface

// File: rtl/rgb_clip.sv
// One colour channel: round the 16-fraction-bit accumulator to nearest,
// drop the fraction and saturate into [0, 2^DATA_W-1].
module rgb_clip
   import yuv2rgb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = DATA_W + 20
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic        [DATA_W-1:0] pix
);
   localparam int TW = ACC_W - FRAC_BITS + 1;
   localparam logic signed [TW-1:0] T_MAX = TW'((1 << DATA_W) - 1);

   logic signed [ACC_W:0]  rnd;
   logic signed [TW-1:0]   t;

   // One guard bit so the rounding add can never wrap.
   assign rnd = (ACC_W+1)'(acc) + (ACC_W+1)'(ROUND_HALF);
   assign t   = rnd[ACC_W:FRAC_BITS];

   always_comb begin
      pix = t[DATA_W-1:0];
      if (t[TW-1])        pix = '0;
      else if (t > T_MAX) pix = '1;
   end
endmodule

// File: rtl/yuv2rgb_pipe.sv
// Multi-cycle YUV-to-RGB converter: Y, V and U terms are accumulated over three
// cycles on two shared multipliers, then rounded, clipped and held until taken.
module yuv2rgb_pipe
   import yuv2rgb_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             CLOCK_50_I,
   input  logic             resetn,
   yuv2rgb_pipe_if.slave    bus,
   output logic [CNT_W-1:0] pix_count
);
   localparam int ACC_W = DATA_W + 20;
   localparam int SMP_W = DATA_W + 1;
   localparam int OFF_Y = 16  << (DATA_W - 8);
   localparam int OFF_C = 128 << (DATA_W - 8);

   state_t state, state_n;

   logic signed [SMP_W-1:0] y_r, u_r, v_r, y_s, u_s, v_s;
   logic                    fr_r;
   logic signed [ACC_W-1:0] acc_r, acc_g, acc_b;
   logic signed [ACC_W-1:0] acc_r_n, acc_g_n, acc_b_n;
   logic signed [ACC_W-1:0] prod0, prod1;
   logic signed [COEF_W-1:0] mul0_k, mul1_k;
   logic signed [SMP_W-1:0] mul0_x, mul1_x;
   logic [DATA_W-1:0]       r_clip, g_clip, b_clip;
   logic [DATA_W-1:0]       r_q, g_q, b_q;
   logic                    accept;
   coef_t                   k;

   assign accept = bus.in_valid && (state == S_IDLE);

   // Offset removal happens before the register so the datapath sees signed samples.
   assign y_s = SMP_W'(bus.Y_in) - (bus.full_range ? SMP_W'(0) : SMP_W'(OFF_Y));
   assign u_s = SMP_W'(bus.U_in) - SMP_W'(OFF_C);
   assign v_s = SMP_W'(bus.V_in) - SMP_W'(OFF_C);

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n       = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_n = S_Y;
         end
         S_Y:    state_n = S_V;
         S_V:    state_n = S_U;
         S_U:    state_n = S_OUT;
         S_OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         y_r  <= '0;
         u_r  <= '0;
         v_r  <= '0;
         fr_r <= 1'b0;
      end else if (accept) begin
         y_r  <= y_s;
         u_r  <= u_s;
         v_r  <= v_s;
         fr_r <= bus.full_range;
      end
   end

   assign k = fr_r ? COEF_FULL : COEF_LIM;

   // mul0: KY*y, KRV*v, KBU*u ; mul1: KGV*v, KGU*u
   always_comb begin
      mul0_k = k.ky;
      mul0_x = y_r;
      mul1_k = k.kgv;
      mul1_x = v_r;
      case (state)
         S_V: begin
            mul0_k = k.krv;
            mul0_x = v_r;
         end
         S_U: begin
            mul0_k = k.kbu;
            mul0_x = u_r;
            mul1_k = k.kgu;
            mul1_x = u_r;
         end
         default: ;
      endcase
   end

   assign prod0 = ACC_W'(mul0_k) * ACC_W'(mul0_x);
   assign prod1 = ACC_W'(mul1_k) * ACC_W'(mul1_x);

   always_comb begin
      acc_r_n = acc_r;
      acc_g_n = acc_g;
      acc_b_n = acc_b;
      case (state)
         S_Y: begin
            acc_r_n = prod0;
            acc_g_n = prod0;
            acc_b_n = prod0;
         end
         S_V: begin
            acc_r_n = acc_r + prod0;
            acc_g_n = acc_g - prod1;
         end
         S_U: begin
            acc_g_n = acc_g - prod1;
            acc_b_n = acc_b + prod0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         acc_r <= '0;
         acc_g <= '0;
         acc_b <= '0;
      end else begin
         acc_r <= acc_r_n;
         acc_g <= acc_g_n;
         acc_b <= acc_b_n;
      end
   end

   // Clip the final sums directly so the result lands on the S_U -> S_OUT edge.
   rgb_clip #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_clip_r (.acc(acc_r_n), .pix(r_clip));
   rgb_clip #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_clip_g (.acc(acc_g_n), .pix(g_clip));
   rgb_clip #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_clip_b (.acc(acc_b_n), .pix(b_clip));

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         r_q <= '0;
         g_q <= '0;
         b_q <= '0;
      end else if (state == S_U) begin
         r_q <= r_clip;
         g_q <= g_clip;
         b_q <= b_clip;
      end
   end

   assign bus.R_out = r_q;
   assign bus.G_out = g_q;
   assign bus.B_out = b_q;

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn)                              pix_count <= '0;
      else if (state == S_OUT && bus.out_ready) pix_count <= pix_count + CNT_W'(1);
   end
endmodule

// File: tb/tb_yuv2rgb_pipe.sv
// Random and directed pixels against a plain-arithmetic BT.601 model; checks
// latency, backpressure hold, pixel count wrap and mid-conversion reset.
module tb_yuv2rgb_pipe;
   localparam int DW = 8;
   localparam int CW = 4;

   logic          CLOCK_50_I = 1'b0;
   logic          resetn     = 1'b0;
   logic [CW-1:0] pix_count;

   yuv2rgb_pipe_if #(.DATA_W(DW)) bus ();

   yuv2rgb_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
      .CLOCK_50_I (CLOCK_50_I),
      .resetn     (resetn),
      .bus        (bus.slave),
      .pix_count  (pix_count)
   );

   always #5 CLOCK_50_I = ~CLOCK_50_I;

   int n_chk   = 0;
   int n_err   = 0;
   int exp_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic int clamp_px(input longint acc);
      longint t;
      int     mx;
      mx = (1 << DW) - 1;
      t  = acc + 32768;
      // floor division by 2^16
      if (t >= 0) t = t / 65536;
      else        t = -((-t + 65535) / 65536);
      if (t < 0)  return 0;
      if (t > mx) return mx;
      return int'(t);
   endfunction

   task automatic model(input int y, input int u, input int v, input bit fr,
                        output int r, output int g, output int b);
      longint ky, krv, kgv, kgu, kbu, yy, uu, vv;
      int s;
      s  = 1 << (DW - 8);
      yy = fr ? y : y - 16 * s;
      uu = u - 128 * s;
      vv = v - 128 * s;
      if (fr) begin
         ky = 65536; krv = 91881;  kgv = 46802; kgu = 22554; kbu = 116130;
      end else begin
         ky = 76284; krv = 104595; kgv = 53281; kgu = 25624; kbu = 132251;
      end
      r = clamp_px(ky * yy + krv * vv);
      g = clamp_px(ky * yy - kgv * vv - kgu * uu);
      b = clamp_px(ky * yy + kbu * uu);
   endtask

   // Called at a negedge with the DUT idle.
   task automatic run_pixel(input int y, input int u, input int v, input bit fr,
                            input int hold, input string tag);
      int r, g, b, cyc;
      model(y, u, v, fr, r, g, b);
      bus.Y_in       = DW'(y);
      bus.U_in       = DW'(u);
      bus.V_in       = DW'(v);
      bus.full_range = fr;
      bus.in_valid   = 1'b1;
      @(posedge CLOCK_50_I);
      cyc = 0;
      do begin
         @(negedge CLOCK_50_I);
         cyc++;
         if (cyc <= 3) chk({tag, "/busy_rdy"}, 32'(bus.in_ready), 0);
         // junk on the inputs while busy must not disturb the pixel
         bus.in_valid   = 1'($urandom_range(0, 1));
         bus.full_range = 1'($urandom_range(0, 1));
         bus.Y_in       = DW'($urandom);
         bus.U_in       = DW'($urandom);
         bus.V_in       = DW'($urandom);
         bus.out_ready  = (cyc < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      end while (!bus.out_valid && cyc < 20);
      chk({tag, "/latency"}, 32'(cyc), 4);
      chk({tag, "/R"}, 32'(bus.R_out), 32'(r));
      chk({tag, "/G"}, 32'(bus.G_out), 32'(g));
      chk({tag, "/B"}, 32'(bus.B_out), 32'(b));
      repeat (hold) begin
         @(negedge CLOCK_50_I);
         chk({tag, "/hold_vld"}, 32'(bus.out_valid), 1);
         chk({tag, "/hold_rdy"}, 32'(bus.in_ready), 0);
         chk({tag, "/hold_rgb"}, {8'd0, 8'(bus.R_out), 8'(bus.G_out), 8'(bus.B_out)},
             {8'd0, 8'(r), 8'(g), 8'(b)});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge CLOCK_50_I);
      @(negedge CLOCK_50_I);
      bus.out_ready = 1'b0;
      exp_cnt = (exp_cnt + 1) % (1 << CW);
      chk({tag, "/count"}, 32'(pix_count), 32'(exp_cnt));
      chk({tag, "/vld_low"}, 32'(bus.out_valid), 0);
      chk({tag, "/rdy_back"}, 32'(bus.in_ready), 1);
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b0;
      bus.full_range = 1'b0;
      bus.Y_in       = '0;
      bus.U_in       = '0;
      bus.V_in       = '0;

      #12;
      chk("rst/in_ready", 32'(bus.in_ready), 1);
      chk("rst/out_valid", 32'(bus.out_valid), 0);
      chk("rst/rgb", {8'd0, 8'(bus.R_out), 8'(bus.G_out), 8'(bus.B_out)}, 0);
      chk("rst/count", 32'(pix_count), 0);
      @(negedge CLOCK_50_I);
      resetn = 1'b1;

      run_pixel(16, 128, 128, 1'b0, 0, "black");
      run_pixel(235, 128, 128, 1'b0, 0, "white");
      run_pixel(81, 90, 240, 1'b0, 0, "sat_red");
      run_pixel(255, 255, 255, 1'b0, 0, "sat_high");
      run_pixel(0, 128, 128, 1'b0, 0, "sub_black");
      run_pixel(200, 128, 128, 1'b1, 0, "full");
      run_pixel(200, 128, 128, 1'b0, 0, "lim_after_full");
      run_pixel(120, 60, 200, 1'b0, 10, "backpressure");

      // reset while in S_V
      bus.Y_in = 8'd150; bus.U_in = 8'd100; bus.V_in = 8'd180;
      bus.full_range = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge CLOCK_50_I);
      @(negedge CLOCK_50_I);
      bus.in_valid = 1'b0;
      @(posedge CLOCK_50_I);
      #2 resetn = 1'b0;
      #1;
      exp_cnt = 0;
      chk("midrst/out_valid", 32'(bus.out_valid), 0);
      chk("midrst/count", 32'(pix_count), 0);
      chk("midrst/in_ready", 32'(bus.in_ready), 1);
      @(negedge CLOCK_50_I);
      resetn = 1'b1;
      run_pixel(150, 100, 180, 1'b0, 0, "post_rst");

      // enough pixels to wrap the 4-bit counter
      for (int i = 0; i < 20; i++)
         run_pixel(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)), "rand");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/yuv2rgb_pipe.md
YUV2RGB_PIPE -- requirements
Module: yuv2rgb_pipe

Interface
REQ-001 Parameter DATA_W, default 8, is the bit width of each Y/U/V input sample and each R/G/B output sample; legal range is 8..12.
REQ-002 Parameter CNT_W, default 16, is the width of the converted-pixel counter.
REQ-003 Port CLOCK_50_I, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-004 Port resetn, input, 1 bit: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit: the Y/U/V sample on the inputs is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept a sample this cycle.
REQ-007 Ports Y_in, U_in and V_in, inputs, each DATA_W bits, unsigned samples.
REQ-008 Port full_range, input, 1 bit: 0 selects BT.601 limited range, 1 selects full range; it is sampled on accept.
REQ-009 Port out_valid, output, 1 bit: R/G/B output is valid.
REQ-010 Port out_ready, input, 1 bit: the downstream side takes the output.
REQ-011 Ports R_out, G_out and B_out, outputs, each DATA_W bits, unsigned and clipped.
REQ-012 Port pix_count, output, CNT_W bits: number of pixels delivered.

Function
REQ-013 An accept occurs on a rising edge where in_valid and in_ready are both 1; Y/U/V and full_range are registered on that edge.
REQ-014 The FSM states are S_IDLE, S_Y, S_V, S_U and S_OUT; in_ready is 1 only in S_IDLE.
REQ-015 S_IDLE goes to S_Y on accept and stays in S_IDLE otherwise.
REQ-016 S_Y goes to S_V, then S_V goes to S_U, then S_U goes to S_OUT, with one cycle per state.
REQ-017 In S_OUT, out_valid is 1; on out_ready the FSM returns to S_IDLE, otherwise it holds in S_OUT.
REQ-018 Accept-to-out_valid latency is exactly 4 cycles, and steady-state throughput is 1 pixel per 5 cycles.
REQ-019 Exactly two signed multipliers are shared across S_Y, S_V and S_U:
- S_Y loads the R, G and B accumulators with KY*y.
- S_V adds KRV*v to R and subtracts KGV*v from G.
- S_U subtracts KGU*u from G and adds KBU*u to B.
REQ-020 The offsets scale with width, where S = 2^(DATA_W-8):
- limited range: y = Y-16*S;
- full range: y = Y;
- in both modes: u = U-128*S and v = V-128*S.
REQ-021 The coefficients are signed, with 16 fractional bits:
- limited range: KY=76284, KRV=104595, KGV=53281, KGU=25624, KBU=132251;
- full range: KY=65536, KRV=91881, KGV=46802, KGU=22554, KBU=116130.
REQ-022 The accumulators are signed, DATA_W+20 bits, and never overflow for any input.
REQ-023 Output rounding and clipping: compute t = (acc + 32768) >>> 16; if t < 0 the output is 0; if t > 2^DATA_W-1 the output is 2^DATA_W-1; otherwise the output is t.
REQ-024 R_out, G_out and B_out are registered on the S_U-to-S_OUT edge and stay stable while out_valid=1 and out_ready=0.
REQ-025 pix_count increments on each out_valid and out_ready handshake, and wraps from 2^CNT_W-1 to 0.
REQ-026 in_valid and full_range are ignored outside S_IDLE, and changes to input data after accept have no effect.
REQ-027 out_ready while out_valid=0 has no effect.

Reset
REQ-028 While resetn=0, the following hold regardless of the clock: state=S_IDLE, in_ready=1, out_valid=0, R/G/B_out=0, pix_count=0, and accumulators and input registers are 0.
REQ-029 A reset asserted mid-conversion or in S_OUT discards the pixel with no output and no count.
REQ-030 The first accept is possible on the first rising edge after resetn deasserts.

Structure
REQ-031 Package yuv2rgb_pkg holds the state enum type, the limited-range and full-range coefficient constants, and the constants FRAC_BITS=16 and ROUND_HALF=32768.
REQ-032 One sub-module, rgb_clip, implements the round, shift and saturate operation of REQ-023 for one channel and is instantiated three times.
REQ-033 Simulation-only display statements are not permitted in the synthesizable RTL.

Verification
REQ-034 Black, limited range, DATA_W=8: Y=16, U=128, V=128 -> R/G/B = 0/0/0, with out_valid 4 cycles after accept.
REQ-035 White rounding, limited range: Y=235, U=128, V=128 -> 255/255/255.
REQ-036 Saturation, limited range:
- Y=81, U=90, V=240 -> 254/0/0 (G and B clip low);
- Y=255, U=255, V=255 -> R=255 (clip high);
- Y=0, U=128, V=128 -> 0/0/0.
REQ-037 Full range: Y=200, U=128, V=128, full_range=1 -> 200/200/200; a following limited-range pixel uses the limited-range coefficients.
REQ-038 Backpressure and count: hold out_ready=0 for 10 cycles -> the outputs stay constant and in_ready=0; release -> pix_count increments by 1; with CNT_W=4, 16 pixels -> pix_count wraps to 0.
REQ-039 Reset mid-operation: drop resetn while in S_V -> out_valid=0, pix_count=0 and in_ready=1 immediately; the next pixel converts correctly.
